instruction_fetch_wb: RTL and testbench

Wishbone B4 classic initiator that fetches 32-bit instructions for the eCPU front end and presents them to decode through a valid/ready handshake. It owns the fetch PC, issues single word reads to the instruction memory slave, and handles branch/jump redirects, including a redirect that lands while a bus cycle is outstanding. It reports bus errors as faulting fetch packets.

---
 rtl/instruction_fetch_wb.sv | 157 +++++++++++++++
 tb/tb_instruction_fetch_wb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_wb.sv
// Wishbone B4 classic instruction fetch initiator with a valid/ready packet interface to decode.
// Optional bus timeout is enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch_wb #(
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC       = '0,
  parameter int unsigned            TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  output logic                      cyc_o,
  output logic                      stb_o,
  output logic                      we_o,
  output logic [ADDR_WIDTH-1:0]     adr_o,
  output logic [DATA_WIDTH-1:0]     dat_o,
  output logic [DATA_WIDTH/8-1:0]   sel_o,
  input  logic                      ack_i,
  input  logic [DATA_WIDTH-1:0]     dat_i,
  input  logic                      err_i,
  output logic                      instr_valid_o,
  input  logic                      instr_ready_i,
  output logic [DATA_WIDTH-1:0]     instr_o,
  output logic [ADDR_WIDTH-1:0]     instr_pc_o,
  output logic                      instr_fault_o,
  input  logic                      redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0]     redirect_pc_i
);

  typedef enum logic [2:0] {StIdle, StReq, StHold, StFault, StDiscard} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]   ipc_q, ipc_d;
  logic                    fault_q, fault_d;

  logic bus_active;
  logic tmo_hit;
  logic bus_ack;
  logic bus_err;
  logic bus_resp;

  assign bus_active = (state_q == StReq) || (state_q == StDiscard);
  // A timeout behaves like a bus error; err_i wins over ack_i.
  assign bus_err    = bus_active && (err_i || tmo_hit);
  assign bus_ack    = bus_active && ack_i && !bus_err;
  assign bus_resp   = bus_ack || bus_err;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;

  assign tmo_hit = bus_active && !ack_i && !err_i && (tmo_q == 8'(TIMEOUT_CYCLES - 1));

  // Wait counter: restarts on every new bus phase, counts stalled cycles otherwise.
  always_comb begin
    tmo_d = tmo_q;
    if (!bus_active || bus_resp || (state_d != state_q)) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 8'd1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  // No timeout: wait for the slave indefinitely. TIMEOUT_CYCLES has no effect here.
  assign tmo_hit = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

  // Next-state, PC and packet capture; a redirect overrides every other event.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    fault_d = fault_q;

    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (bus_err) begin
          instr_d = '0;
          ipc_d   = pc_q;
          fault_d = 1'b1;
          state_d = StHold;
        end else if (bus_ack) begin
          instr_d = dat_i;
          ipc_d   = pc_q;
          fault_d = 1'b0;
          pc_d    = pc_q + ADDR_WIDTH'(4);
          state_d = StHold;
        end
      end
      StHold: begin
        if (instr_ready_i) state_d = fault_q ? StFault : StReq;
      end
      StFault: state_d = StFault;
      StDiscard: begin
        if (bus_resp) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase

    if (redirect_valid_i) begin
      pc_d    = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
      instr_d = instr_q;
      ipc_d   = ipc_q;
      fault_d = 1'b0;
      unique case (state_q)
        StReq, StDiscard: state_d = bus_resp ? StReq : StDiscard;
        default:          state_d = StReq;
      endcase
    end

    // Bus address only moves when a fresh request phase begins, so DISCARD keeps the stale one.
    adr_d = (state_d == StReq) ? pc_d : adr_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      adr_q   <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      adr_q   <= adr_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      fault_q <= fault_d;
    end
  end

  assign cyc_o         = bus_active;
  assign stb_o         = bus_active;
  assign we_o          = 1'b0;
  assign adr_o         = adr_q;
  assign dat_o         = '0;
  assign sel_o         = '1;
  assign instr_valid_o = (state_q == StHold);
  assign instr_o       = instr_q;
  assign instr_pc_o    = ipc_q;
  assign instr_fault_o = fault_q;

endmodule

// File: tb/tb_instruction_fetch_wb.sv
// Directed self-checking bench for instruction_fetch_wb.
module tb_instruction_fetch_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_o;
  logic [3:0]  sel;
  logic        ack, err;
  logic [31:0] dat_i;
  logic        ivalid, iready, ifault;
  logic [31:0] instr, ipc;
  logic        redir;
  logic [31:0] redir_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instruction_fetch_wb #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .RESET_PC       (32'h0),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .cyc_o            (cyc),
    .stb_o            (stb),
    .we_o             (we),
    .adr_o            (adr),
    .dat_o            (dat_o),
    .sel_o            (sel),
    .ack_i            (ack),
    .dat_i            (dat_i),
    .err_i            (err),
    .instr_valid_o    (ivalid),
    .instr_ready_i    (iready),
    .instr_o          (instr),
    .instr_pc_o       (ipc),
    .instr_fault_o    (ifault),
    .redirect_valid_i (redir),
    .redirect_pc_i    (redir_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; ack = 1'b0; err = 1'b0; dat_i = '0;
    iready = 1'b0; redir = 1'b0; redir_pc = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_cyc", {31'd0, cyc}, 32'd0);
    chk("rst_stb", {31'd0, stb}, 32'd0);
    chk("rst_valid", {31'd0, ivalid}, 32'd0);
    chk("rst_fault", {31'd0, ifault}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_ipc", ipc, 32'd0);
    chk("tie_we", {31'd0, we}, 32'd0);
    chk("tie_sel", {28'd0, sel}, 32'hF);
    chk("tie_dat", dat_o, 32'd0);
    rst_n = 1'b1;

`ifndef FETCH_TIMEOUT_EN
    // 1: two back-to-back fetches from reset
    @(negedge clk);
    chk("t1_req0_cyc", {31'd0, cyc}, 32'd1);
    chk("t1_req0_adr", adr, 32'h0);
    ack = 1'b1; dat_i = 32'h00500093; iready = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("t1_p0_valid", {31'd0, ivalid}, 32'd1);
    chk("t1_p0_instr", instr, 32'h00500093);
    chk("t1_p0_pc", ipc, 32'h0);
    chk("t1_p0_fault", {31'd0, ifault}, 32'd0);
    chk("t1_p0_cyc", {31'd0, cyc}, 32'd0);
    @(negedge clk);
    chk("t1_req1_adr", adr, 32'h4);
    chk("t1_req1_valid", {31'd0, ivalid}, 32'd0);
    ack = 1'b1; dat_i = 32'h00A00113;
    @(negedge clk);
    ack = 1'b0; iready = 1'b0;
    chk("t1_p1_instr", instr, 32'h00A00113);
    chk("t1_p1_pc", ipc, 32'h4);
    chk("t1_p1_fault", {31'd0, ifault}, 32'd0);

    // 2: backpressure holds the packet steady
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_valid", {31'd0, ivalid}, 32'd1);
      chk("t2_instr", instr, 32'h00A00113);
      chk("t2_pc", ipc, 32'h4);
      chk("t2_cyc", {31'd0, cyc}, 32'd0);
    end
    iready = 1'b1;

    // 3: redirect to 0x103 while fetch at 0x8 is stalled
    @(negedge clk);
    iready = 1'b0;
    chk("t3_req_adr", adr, 32'h8);
    redir = 1'b1; redir_pc = 32'h103;
    @(negedge clk);
    redir = 1'b0;
    chk("t3_disc_adr", adr, 32'h8);
    chk("t3_disc_cyc", {31'd0, cyc}, 32'd1);
    chk("t3_disc_valid", {31'd0, ivalid}, 32'd0);
    @(negedge clk);
    chk("t3_disc_adr2", adr, 32'h8);
    ack = 1'b1; dat_i = 32'hDEADBEEF;
    @(negedge clk);
    ack = 1'b0;
    chk("t3_new_adr", adr, 32'h100);
    chk("t3_new_cyc", {31'd0, cyc}, 32'd1);
    chk("t3_drop_valid", {31'd0, ivalid}, 32'd0);
    ack = 1'b1; dat_i = 32'h00000013;
    @(negedge clk);
    ack = 1'b0;
    chk("t3_p_valid", {31'd0, ivalid}, 32'd1);
    chk("t3_p_instr", instr, 32'h00000013);
    chk("t3_p_pc", ipc, 32'h100);

    // 4: redirect from HOLD to 0x20 drops the packet, then a bus error there
    redir = 1'b1; redir_pc = 32'h20; iready = 1'b1;
    @(negedge clk);
    redir = 1'b0; iready = 1'b0;
    chk("t4_req_adr", adr, 32'h20);
    chk("t4_req_valid", {31'd0, ivalid}, 32'd0);
    err = 1'b1;
    @(negedge clk);
    err = 1'b0;
    chk("t4_f_valid", {31'd0, ivalid}, 32'd1);
    chk("t4_f_fault", {31'd0, ifault}, 32'd1);
    chk("t4_f_instr", instr, 32'h0);
    chk("t4_f_pc", ipc, 32'h20);
    chk("t4_f_cyc", {31'd0, cyc}, 32'd0);
    iready = 1'b1;
    @(negedge clk);
    iready = 1'b0;
    chk("t4_idle_cyc", {31'd0, cyc}, 32'd0);
    chk("t4_idle_valid", {31'd0, ivalid}, 32'd0);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("t4_idle_cyc2", {31'd0, cyc}, 32'd0);
    chk("t4_idle_valid2", {31'd0, ivalid}, 32'd0);
    redir = 1'b1; redir_pc = 32'h40;
    @(negedge clk);
    redir = 1'b0;
    chk("t4_re_adr", adr, 32'h40);
    chk("t4_re_cyc", {31'd0, cyc}, 32'd1);
    chk("t4_re_fault", {31'd0, ifault}, 32'd0);
    ack = 1'b1; dat_i = 32'h12345678;
    @(negedge clk);
    ack = 1'b0;
    chk("t4_p_pc", ipc, 32'h40);
    chk("t4_p_instr", instr, 32'h12345678);

    // 5: reset during an outstanding fetch at 0x10
    redir = 1'b1; redir_pc = 32'h10;
    @(negedge clk);
    redir = 1'b0;
    chk("t5_req_adr", adr, 32'h10);
    @(negedge clk);
    chk("t5_wait_cyc", {31'd0, cyc}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_cyc", {31'd0, cyc}, 32'd0);
    chk("t5_rst_valid", {31'd0, ivalid}, 32'd0);
    rst_n = 1'b1; ack = 1'b1; dat_i = 32'hBAD0BAD0;
    @(negedge clk);
    ack = 1'b0;
    chk("t5_restart_adr", adr, 32'h0);
    chk("t5_restart_cyc", {31'd0, cyc}, 32'd1);
    chk("t5_late_ack_valid", {31'd0, ivalid}, 32'd0);
    ack = 1'b1; dat_i = 32'h11111111;
    @(negedge clk);
    ack = 1'b0;
    chk("t5_p_pc", ipc, 32'h0);
    chk("t5_p_instr", instr, 32'h11111111);

    // ack and err together: err wins
    iready = 1'b1;
    @(negedge clk);
    iready = 1'b0;
    chk("t6_req_adr", adr, 32'h4);
    ack = 1'b1; err = 1'b1; dat_i = 32'h55555555;
    @(negedge clk);
    ack = 1'b0; err = 1'b0;
    chk("t6_fault", {31'd0, ifault}, 32'd1);
    chk("t6_instr", instr, 32'h0);
    chk("t6_pc", ipc, 32'h4);

    // redirect in the same cycle as an ack drops that response
    redir = 1'b1; redir_pc = 32'h200;
    @(negedge clk);
    chk("t7_req_adr", adr, 32'h200);
    redir_pc = 32'h301; ack = 1'b1; dat_i = 32'h22222222;
    @(negedge clk);
    redir = 1'b0; ack = 1'b0;
    chk("t7_new_adr", adr, 32'h300);
    chk("t7_cyc", {31'd0, cyc}, 32'd1);
    chk("t7_valid", {31'd0, ivalid}, 32'd0);
    chk("t7_fault", {31'd0, ifault}, 32'd0);
`else
    // Timeout: slave never answers the fetch at 0x0
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_wait_cyc", {31'd0, cyc}, 32'd1);
      chk("to_wait_adr", adr, 32'h0);
    end
    @(negedge clk);
    chk("to_drop_cyc", {31'd0, cyc}, 32'd0);
    chk("to_valid", {31'd0, ivalid}, 32'd1);
    chk("to_fault", {31'd0, ifault}, 32'd1);
    chk("to_pc", ipc, 32'h0);
    chk("to_instr", instr, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
